dog_ctl: RTL and testbench
==========================

Name: dog_ctl

Overview:
- Per-frame motion and animation controller for the intro dog sprite.
- Produces the sprite top-left position (xpos, ypos) and sprite frame select consumed by the dog drawing stage.
- Runs the walk -> sniff -> jump -> fall sequence, advancing once per video frame on the rising edge of vblnk.
- Sits between game control (game_enable) and the dog draw/ROM path; reports completion to the game FSM.

Parameters:
X_START, 0, walk start x position (px)
X_STOP, 400, x position where walking ends (px); must be >= X_START
WALK_STEP, 2, x increment per frame while walking
ANIM_DIV, 8, frames per walk-sprite toggle
SNIFF_FRAMES, 30, frames spent sniffing
Y_GROUND, 520, resting y position (px)
JUMP_HEIGHT, 120, jump apex offset above Y_GROUND; must be <= Y_GROUND
JUMP_STEP, 4, y change per frame while jumping or falling

Ports:
clk  in  1  system/pixel clock
rst  in  1  synchronous, active-high reset
game_enable  in  1  level; high runs the intro sequence, low aborts it
vblnk  in  1  vertical blanking from the VGA timing chain
xpos  out  12  sprite x position
ypos  out  12  sprite y position
sprite_sel  out  2  sprite frame: 0 walk A, 1 walk B, 2 sniff, 3 jump
dog_visible  out  1  high while the dog is to be drawn
intro_done  out  1  level; high in DONE

Behaviour:
- Reset: state IDLE; xpos=X_START; ypos=Y_GROUND; sprite_sel=0; dog_visible=0; intro_done=0; all counters 0; vblnk_d=0.
- Frame tick: tick = vblnk & ~vblnk_d, where vblnk_d is vblnk registered one clock. Exactly one tick per frame.
- Register timing: all outputs are registered. The state and position update takes effect on the clock edge that samples tick=1.
- Abort: game_enable=0 in any state forces the IDLE/reset values on the next edge. This path does not wait for a tick and has priority over tick processing.
- IDLE:
  - Outputs hold their reset values.
  - On a tick with game_enable=1: go to WALK, set dog_visible=1, clear the anim counter. xpos does not move on this tick.
- WALK, per tick:
  - If xpos + WALK_STEP >= X_STOP: set xpos=X_STOP (saturate, never overshoot), clear the frame counter, set sprite_sel=2, go to SNIFF.
  - Otherwise: xpos += WALK_STEP.
  - Anim counter counts 0..ANIM_DIV-1. On wrap, sprite_sel toggles between 0 and 1.
- SNIFF, per tick:
  - sprite_sel=2; the frame counter increments.
  - When the counter reaches SNIFF_FRAMES-1 on a tick: go to JUMP_UP, set sprite_sel=3.
  - Total time in SNIFF is exactly SNIFF_FRAMES ticks.
- JUMP_UP, per tick:
  - If ypos - JUMP_STEP <= Y_GROUND - JUMP_HEIGHT: set ypos=Y_GROUND-JUMP_HEIGHT (clamp at apex), go to FALL.
  - Otherwise: ypos -= JUMP_STEP.
- FALL, per tick:
  - If ypos + JUMP_STEP >= Y_GROUND: set ypos=Y_GROUND, dog_visible=0, intro_done=1, go to DONE.
  - Otherwise: ypos += JUMP_STEP.
  - sprite_sel stays 3.
- DONE:
  - All outputs hold.
  - Leaves only via game_enable=0 (to IDLE) or rst.
- Arithmetic: 12-bit unsigned. Comparisons use a 13-bit intermediate so no wrap-around occurs in the step/compare logic. xpos stays in [X_START, X_STOP]; ypos stays in [Y_GROUND-JUMP_HEIGHT, Y_GROUND].
- Simultaneous events:
  - rst beats everything.
  - game_enable=0 beats a tick.
  - A tick arriving in the same cycle that game_enable rises is honoured.
- Reset or abort mid-sequence: the sequence restarts from IDLE. No stale counter values carry over.

Test Plan:
- Reset then idle: rst for 3 clk with game_enable=0, many vblnk pulses -> xpos=0, ypos=520, sprite_sel=0, dog_visible=0, intro_done=0 throughout.
- Walk: game_enable=1, 1 start tick, then 100 ticks -> dog_visible=1, xpos=200, sprite_sel toggled 12 times (value 0 at tick 96..99).
- Walk saturation and sniff: X_STOP=401 -> final walk tick gives xpos=401, not 402; then sprite_sel=2 for exactly 30 ticks before going to 3.
- Jump/fall: from SNIFF exit -> ypos reaches 400 after 30 ticks, returns to 520 after 30 more; on that tick dog_visible=0 and intro_done=1.
- Abort: game_enable drops mid-JUMP_UP with ypos=460, no tick present -> next clk ypos=520, xpos=0, state IDLE, intro_done=0.
- Tick edge detection: vblnk held high for 1000 clk -> only one position step; vblnk toggling within the same clk as game_enable rising -> WALK entered on that edge.

Source files
------------

// File: rtl/dog_ctl_if.sv
// Bus between game control and the intro dog motion controller.
// The master drives enable and frame timing; the slave returns sprite placement and status.
interface dog_ctl_if;
  logic        game_enable;
  logic        vblnk;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [1:0]  sprite_sel;
  logic        dog_visible;
  logic        intro_done;

  modport master (
    output game_enable, vblnk,
    input  xpos, ypos, sprite_sel, dog_visible, intro_done
  );

  modport slave (
    input  game_enable, vblnk,
    output xpos, ypos, sprite_sel, dog_visible, intro_done
  );
endinterface

// File: rtl/dog_ctl.sv
// Intro dog controller: walk -> sniff -> jump -> fall.
// The sequence advances once per video frame, on the rising edge of vblnk.
module dog_ctl #(
  parameter int X_START      = 0,
  parameter int X_STOP       = 400,
  parameter int WALK_STEP    = 2,
  parameter int ANIM_DIV     = 8,
  parameter int SNIFF_FRAMES = 30,
  parameter int Y_GROUND     = 520,
  parameter int JUMP_HEIGHT  = 120,
  parameter int JUMP_STEP    = 4
) (
  input  logic     clk,
  input  logic     rst,
  dog_ctl_if.slave dog
);
  typedef enum logic [2:0] {S_IDLE, S_WALK, S_SNIFF, S_JUMP_UP, S_FALL, S_DONE} state_t;

  localparam int ANIM_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int SNIFF_W = (SNIFF_FRAMES > 1) ? $clog2(SNIFF_FRAMES) : 1;

  localparam logic [11:0] X_START_C = 12'(X_START);
  localparam logic [11:0] X_STOP_C  = 12'(X_STOP);
  localparam logic [11:0] Y_GND_C   = 12'(Y_GROUND);
  localparam logic [11:0] Y_APEX_C  = 12'(Y_GROUND - JUMP_HEIGHT);

  state_t               r_state, w_state_next;
  logic                 r_vblnk_d;
  logic [11:0]          r_xpos, w_xpos_next;
  logic [11:0]          r_ypos, w_ypos_next;
  logic [1:0]           r_sprite_sel, w_sprite_sel_next;
  logic                 r_dog_visible, w_dog_visible_next;
  logic                 r_intro_done, w_intro_done_next;
  logic [ANIM_W-1:0]    r_anim_cnt, w_anim_cnt_next;
  logic [SNIFF_W-1:0]   r_frame_cnt, w_frame_cnt_next;

  logic                 w_tick;
  logic [12:0]          w_x_sum;
  logic [12:0]          w_y_sum;
  logic [12:0]          w_y_rise_lim;

  assign w_tick  = dog.vblnk & ~r_vblnk_d;
  assign w_x_sum = {1'b0, r_xpos} + 13'(WALK_STEP);
  assign w_y_sum = {1'b0, r_ypos} + 13'(JUMP_STEP);
  // ypos - step <= apex rewritten as ypos <= apex + step so nothing can underflow.
  assign w_y_rise_lim = {1'b0, Y_APEX_C} + 13'(JUMP_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_vblnk_d     <= 1'b0;
      r_xpos        <= X_START_C;
      r_ypos        <= Y_GND_C;
      r_sprite_sel  <= 2'd0;
      r_dog_visible <= 1'b0;
      r_intro_done  <= 1'b0;
      r_anim_cnt    <= '0;
      r_frame_cnt   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_vblnk_d     <= dog.vblnk;
      r_xpos        <= w_xpos_next;
      r_ypos        <= w_ypos_next;
      r_sprite_sel  <= w_sprite_sel_next;
      r_dog_visible <= w_dog_visible_next;
      r_intro_done  <= w_intro_done_next;
      r_anim_cnt    <= w_anim_cnt_next;
      r_frame_cnt   <= w_frame_cnt_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_xpos_next        = r_xpos;
    w_ypos_next        = r_ypos;
    w_sprite_sel_next  = r_sprite_sel;
    w_dog_visible_next = r_dog_visible;
    w_intro_done_next  = r_intro_done;
    w_anim_cnt_next    = r_anim_cnt;
    w_frame_cnt_next   = r_frame_cnt;

    // Abort wins over the frame tick and does not wait for one.
    if (!dog.game_enable) begin
      w_state_next       = S_IDLE;
      w_xpos_next        = X_START_C;
      w_ypos_next        = Y_GND_C;
      w_sprite_sel_next  = 2'd0;
      w_dog_visible_next = 1'b0;
      w_intro_done_next  = 1'b0;
      w_anim_cnt_next    = '0;
      w_frame_cnt_next   = '0;
    end else if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          w_state_next       = S_WALK;
          w_dog_visible_next = 1'b1;
          w_anim_cnt_next    = '0;
        end
        S_WALK: begin
          if (w_x_sum >= {1'b0, X_STOP_C}) begin
            w_xpos_next       = X_STOP_C;
            w_frame_cnt_next  = '0;
            w_sprite_sel_next = 2'd2;
            w_state_next      = S_SNIFF;
          end else begin
            w_xpos_next = w_x_sum[11:0];
            if (r_anim_cnt == ANIM_W'(ANIM_DIV - 1)) begin
              w_anim_cnt_next   = '0;
              w_sprite_sel_next = {1'b0, ~r_sprite_sel[0]};
            end else begin
              w_anim_cnt_next = r_anim_cnt + 1'b1;
            end
          end
        end
        S_SNIFF: begin
          w_sprite_sel_next = 2'd2;
          w_frame_cnt_next  = r_frame_cnt + 1'b1;
          if (r_frame_cnt == SNIFF_W'(SNIFF_FRAMES - 1)) begin
            w_state_next      = S_JUMP_UP;
            w_sprite_sel_next = 2'd3;
          end
        end
        S_JUMP_UP: begin
          if ({1'b0, r_ypos} <= w_y_rise_lim) begin
            w_ypos_next  = Y_APEX_C;
            w_state_next = S_FALL;
          end else begin
            w_ypos_next = r_ypos - 12'(JUMP_STEP);
          end
        end
        S_FALL: begin
          w_sprite_sel_next = 2'd3;
          if (w_y_sum >= {1'b0, Y_GND_C}) begin
            w_ypos_next        = Y_GND_C;
            w_dog_visible_next = 1'b0;
            w_intro_done_next  = 1'b1;
            w_state_next       = S_DONE;
          end else begin
            w_ypos_next = w_y_sum[11:0];
          end
        end
        S_DONE: begin
          w_state_next = S_DONE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  assign dog.xpos        = r_xpos;
  assign dog.ypos        = r_ypos;
  assign dog.sprite_sel  = r_sprite_sel;
  assign dog.dog_visible = r_dog_visible;
  assign dog.intro_done  = r_intro_done;
endmodule

// File: tb/tb_dog_ctl.sv
// Directed bench for dog_ctl: full intro sequence, saturation/clamp limits, abort and tick edge cases.
// X_STOP is 401 so the walk saturates on a non-multiple of WALK_STEP.
module tb_dog_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dog_ctl_if bus();

  dog_ctl #(.X_STOP(401)) dut (
    .clk (clk),
    .rst (rst),
    .dog (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int x, input int y, input int s,
                           input int v, input int d);
    $display("%-12s t=%0t xpos=%0d ypos=%0d sel=%0d vis=%0d done=%0d", tag, $time,
             bus.xpos, bus.ypos, bus.sprite_sel, bus.dog_visible, bus.intro_done);
    check({tag, ".xpos"}, 16'(bus.xpos), 16'(x));
    check({tag, ".ypos"}, 16'(bus.ypos), 16'(y));
    check({tag, ".sel"},  16'(bus.sprite_sel), 16'(s));
    check({tag, ".vis"},  16'(bus.dog_visible), 16'(v));
    check({tag, ".done"}, 16'(bus.intro_done), 16'(d));
  endtask

  // One-clock vblnk pulse; starts and ends on a falling edge, so outputs are settled on return.
  task automatic tick();
    bus.vblnk = 1'b1;
    @(negedge clk);
    bus.vblnk = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.game_enable = 1'b0;
    bus.vblnk       = 1'b0;

    // Reset with vblnk activity present
    rst = 1'b1;
    @(negedge clk); bus.vblnk = 1'b1;
    @(negedge clk); bus.vblnk = 1'b0;
    @(negedge clk); bus.vblnk = 1'b1;
    @(negedge clk); bus.vblnk = 1'b0;
    rst = 1'b0;
    check_all("reset", 0, 520, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_all("idle", 0, 520, 0, 0, 0);
    end

    // Tick in the same cycle game_enable rises: WALK entered, no movement yet
    bus.game_enable = 1'b1;
    bus.vblnk       = 1'b1;
    @(negedge clk);
    bus.vblnk = 1'b0;
    check_all("start", 0, 520, 0, 1, 0);
    @(negedge clk);

    for (int k = 1; k <= 100; k++) begin
      tick();
      check_all("walk", 2 * k, 520, (k / 8) % 2, 1, 0);
    end

    // vblnk held high: only a single step
    bus.vblnk = 1'b1;
    repeat (1000) @(negedge clk);
    bus.vblnk = 1'b0;
    @(negedge clk);
    check_all("held", 202, 520, 0, 1, 0);

    for (int k = 102; k <= 200; k++) begin
      tick();
      check_all("walk2", 2 * k, 520, (k / 8) % 2, 1, 0);
    end
    tick();
    check_all("saturate", 401, 520, 2, 1, 0);

    for (int k = 1; k <= 29; k++) begin
      tick();
      check_all("sniff", 401, 520, 2, 1, 0);
    end
    tick();
    check_all("sniff_exit", 401, 520, 3, 1, 0);

    for (int k = 1; k <= 29; k++) begin
      tick();
      check_all("jump", 401, 520 - 4 * k, 3, 1, 0);
    end
    tick();
    check_all("apex", 401, 400, 3, 1, 0);

    for (int k = 1; k <= 29; k++) begin
      tick();
      check_all("fall", 401, 400 + 4 * k, 3, 1, 0);
    end
    tick();
    check_all("land", 401, 520, 3, 0, 1);

    for (int k = 0; k < 3; k++) begin
      tick();
      check_all("done_hold", 401, 520, 3, 0, 1);
    end

    // Abort from DONE without a tick
    bus.game_enable = 1'b0;
    @(negedge clk);
    check_all("abort_done", 0, 520, 0, 0, 0);

    // Abort beats a coincident tick
    bus.game_enable = 1'b1;
    tick();
    tick();
    check_all("rewalk", 2, 520, 0, 1, 0);
    bus.game_enable = 1'b0;
    bus.vblnk       = 1'b1;
    @(negedge clk);
    bus.vblnk = 1'b0;
    check_all("abort_tick", 0, 520, 0, 0, 0);
    @(negedge clk);

    // Run up to mid-jump, then abort
    bus.game_enable = 1'b1;
    tick();
    check_all("start2", 0, 520, 0, 1, 0);
    repeat (201) tick();
    check_all("sat2", 401, 520, 2, 1, 0);
    repeat (30) tick();
    repeat (15) tick();
    check_all("mid_jump", 401, 460, 3, 1, 0);
    bus.game_enable = 1'b0;
    @(negedge clk);
    check_all("abort_jump", 0, 520, 0, 0, 0);

    // Restart is clean: anim counter begins at zero again
    bus.game_enable = 1'b1;
    tick();
    check_all("start3", 0, 520, 0, 1, 0);
    repeat (7) tick();
    check_all("anim7", 14, 520, 0, 1, 0);
    tick();
    check_all("anim8", 16, 520, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
